// File: rtl/regfile_dual.sv
// Dual-issue integer register file: 31 x 32-bit registers, two write lanes,
// four combinational write-through read ports. x0 is hard-wired to zero.

module regfile_dual_rport (
    input  logic        rst,
    input  logic [4:0]  raddr,
    input  logic [31:0] stored,
    input  logic        wr1_ok,
    input  logic [4:0]  waddr1,
    input  logic [31:0] wdata1,
    input  logic        wr2_ok,
    input  logic [4:0]  waddr2,
    input  logic [31:0] wdata2,
    output logic [31:0] rdata
);
    // wr1_ok/wr2_ok already carry conflict resolution, so at most one of
    // them can match a given address and the bypass equals what commits.
    always_comb begin
        rdata = '0;
        if (!rst && raddr != 5'd0) begin
            if (wr2_ok && waddr2 == raddr)
                rdata = wdata2;
            else if (wr1_ok && waddr1 == raddr)
                rdata = wdata1;
            else
                rdata = stored;
        end
    end
endmodule

module regfile_dual (
    input  logic        clk,
    input  logic        rst,
    input  logic        we1,
    input  logic [4:0]  waddr1,
    input  logic [31:0] wdata1,
    input  logic        num1,
    input  logic        we2,
    input  logic [4:0]  waddr2,
    input  logic [31:0] wdata2,
    input  logic        num2,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    input  logic [4:0]  raddr3,
    input  logic [4:0]  raddr4,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    output logic [31:0] rdata3,
    output logic [31:0] rdata4
);
    localparam int NUM_RPORTS = 4;

    logic [31:0] regs_q [1:31];
    logic [31:0] regs_d [1:31];
    logic [31:0][31:0] regs_view;

    logic v1, v2, same_addr, lane1_wins, wr1_ok, wr2_ok;

    // Lane 1 only beats lane 2 when it is strictly the younger instruction.
    assign v1         = we1 && (waddr1 != 5'd0);
    assign v2         = we2 && (waddr2 != 5'd0);
    assign same_addr  = v1 && v2 && (waddr1 == waddr2);
    assign lane1_wins = num1 && !num2;
    assign wr1_ok     = v1 && !(same_addr && !lane1_wins);
    assign wr2_ok     = v2 && !(same_addr && lane1_wins);

    always_comb begin
        regs_d = regs_q;
        if (wr1_ok)
            regs_d[waddr1] = wdata1;
        if (wr2_ok)
            regs_d[waddr2] = wdata2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++)
                regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign regs_view[0] = '0;
    for (genvar g = 1; g < 32; g++) begin : g_view
        assign regs_view[g] = regs_q[g];
    end

    logic [NUM_RPORTS-1:0][4:0]  raddr_v;
    logic [NUM_RPORTS-1:0][31:0] rdata_v;

    assign raddr_v = {raddr4, raddr3, raddr2, raddr1};

    for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
        regfile_dual_rport u_rport (
            .rst    (rst),
            .raddr  (raddr_v[p]),
            .stored (regs_view[raddr_v[p]]),
            .wr1_ok (wr1_ok),
            .waddr1 (waddr1),
            .wdata1 (wdata1),
            .wr2_ok (wr2_ok),
            .waddr2 (waddr2),
            .wdata2 (wdata2),
            .rdata  (rdata_v[p])
        );
    end

    assign rdata1 = rdata_v[0];
    assign rdata2 = rdata_v[1];
    assign rdata3 = rdata_v[2];
    assign rdata4 = rdata_v[3];
endmodule

// File: tb/tb_regfile_dual.sv
// Bench for regfile_dual: directed scenarios plus randomized traffic checked
// against an array model with explicit write-priority rules.

module tb_regfile_dual;
    logic        clk = 1'b0;
    logic        rst;
    logic        we1, we2, num1, num2;
    logic [4:0]  waddr1, waddr2, raddr1, raddr2, raddr3, raddr4;
    logic [31:0] wdata1, wdata2;
    logic [31:0] rdata1, rdata2, rdata3, rdata4;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] model [0:31];

    always #5 clk = ~clk;

    regfile_dual dut (
        .clk(clk), .rst(rst),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .num1(num1),
        .we2(we2), .waddr2(waddr2), .wdata2(wdata2), .num2(num2),
        .raddr1(raddr1), .raddr2(raddr2), .raddr3(raddr3), .raddr4(raddr4),
        .rdata1(rdata1), .rdata2(rdata2), .rdata3(rdata3), .rdata4(rdata4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Value a read of address a must show this cycle, given the current inputs.
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        logic h1, h2;
        if (rst || a == 5'd0) return 32'h0;
        h1 = we1 && waddr1 == a;
        h2 = we2 && waddr2 == a;
        if (h1 && h2) return (num1 && !num2) ? wdata1 : wdata2;
        if (h1) return wdata1;
        if (h2) return wdata2;
        return model[a];
    endfunction

    // Apply the cycle's writes to the model: losing lane first, winner last.
    task automatic model_commit();
        if (rst) begin
            foreach (model[i]) model[i] = 32'h0;
        end else if (num1 && !num2) begin
            if (we2) model[waddr2] = wdata2;
            if (we1) model[waddr1] = wdata1;
        end else begin
            if (we1) model[waddr1] = wdata1;
            if (we2) model[waddr2] = wdata2;
        end
        model[0] = 32'h0;
    endtask

    // Called just after a negedge with inputs settled: check all ports, clock, commit.
    task automatic step();
        #1;
        chk("rd1", rdata1, exp_rd(raddr1));
        chk("rd2", rdata2, exp_rd(raddr2));
        chk("rd3", rdata3, exp_rd(raddr3));
        chk("rd4", rdata4, exp_rd(raddr4));
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic idle();
        we1 = 0; we2 = 0; num1 = 0; num2 = 0;
        waddr1 = 0; waddr2 = 0; wdata1 = 0; wdata2 = 0;
    endtask

    task automatic conflict7(input logic n1, input logic n2, input logic [31:0] exp);
        we1 = 1; waddr1 = 7; wdata1 = 32'h11; num1 = n1;
        we2 = 1; waddr2 = 7; wdata2 = 32'h22; num2 = n2;
        raddr1 = 7;
        #1 chk("conf_byp", rdata1, exp);
        step();
        idle();
        #1 chk("conf_x7", rdata1, exp);
        step();
    endtask

    initial begin
        foreach (model[i]) model[i] = 32'h0;
        idle();
        rst = 1; raddr1 = 1; raddr2 = 2; raddr3 = 31; raddr4 = 0;
        we1 = 1; waddr1 = 1; wdata1 = 32'hDEAD_BEEF;
        @(negedge clk);
        #1 chk("rst_byp_off", rdata1, 32'h0);
        step();
        step();
        rst = 0; idle();
        #1;
        chk("rst_r1", rdata1, 32'h0);
        chk("rst_r2", rdata2, 32'h0);
        chk("rst_r31", rdata3, 32'h0);
        chk("rst_r0", rdata4, 32'h0);
        step();

        // distinct-address dual write
        we1 = 1; waddr1 = 5; wdata1 = 32'hAAAA_0001;
        we2 = 1; waddr2 = 6; wdata2 = 32'hBBBB_0002;
        step();
        idle(); raddr1 = 5; raddr2 = 6;
        #1;
        chk("dual_x5", rdata1, 32'hAAAA_0001);
        chk("dual_x6", rdata2, 32'hBBBB_0002);
        step();

        conflict7(1, 0, 32'h11);
        conflict7(0, 1, 32'h22);
        conflict7(1, 1, 32'h22);
        conflict7(0, 0, 32'h22);

        // bypass
        we1 = 1; waddr1 = 9; wdata1 = 32'h5;
        step();
        idle(); raddr3 = 9;
        #1 chk("x9_stored", rdata3, 32'h5);
        we1 = 1; waddr1 = 9; wdata1 = 32'h77;
        #1 chk("byp_l1", rdata3, 32'h77);
        we2 = 1; waddr2 = 9; wdata2 = 32'h99; num2 = 1;
        #1 chk("byp_l2win", rdata3, 32'h99);
        step();
        idle();
        #1 chk("byp_commit", rdata3, 32'h99);
        step();

        // x0 protection
        we1 = 1; we2 = 1; waddr1 = 0; waddr2 = 0;
        wdata1 = 32'hFFFF_FFFF; wdata2 = 32'hFFFF_FFFF; raddr1 = 0;
        #1 chk("x0_same", rdata1, 32'h0);
        step();
        idle();
        #1 chk("x0_next", rdata1, 32'h0);
        step();

        // reset mid-stream
        we1 = 1; waddr1 = 3; wdata1 = 32'hC; raddr2 = 3;
        step();
        rst = 1; we1 = 1; waddr1 = 3; wdata1 = 32'hD;
        #1 chk("mid_rst_rd", rdata2, 32'h0);
        step();
        rst = 0; idle();
        #1 chk("x3_cleared", rdata2, 32'h0);
        step();
        we1 = 1; waddr1 = 3; wdata1 = 32'hE;
        step();
        idle();
        #1 chk("x3_post", rdata2, 32'hE);
        step();

        // random traffic, addresses biased to a small range to force collisions
        for (int c = 0; c < 400; c++) begin
            rst    = ($urandom_range(0, 49) == 0);
            we1    = $urandom_range(0, 1);
            we2    = $urandom_range(0, 1);
            num1   = $urandom_range(0, 1);
            num2   = $urandom_range(0, 1);
            waddr1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            waddr2 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            wdata1 = $urandom;
            wdata2 = $urandom;
            raddr1 = 5'($urandom_range(0, 7));
            raddr2 = 5'($urandom_range(0, 7));
            raddr3 = 5'($urandom_range(0, 31));
            raddr4 = ($urandom_range(0, 1) == 1) ? waddr1 : waddr2;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
